mux_gate_unit: RTL and testbench

Pipelined, parametrised two-input bitwise logic unit. Every result bit is produced by a 4:1 mux indexed by the operand bits {a,b}, selecting from a 4-bit truth table. Six truth tables are fixed, covering the standard gate functions. One table is user-programmable, and one is a pass-through. The block sits between an operand producer and a result consumer, uses valid/ready handshakes on both sides, and adds zero and parity status flags.

---
 rtl/mux_gate_unit.sv | 134 +++++++++++++
 tb/tb_mux_gate_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_gate_unit.sv
// Two-stage valid/ready bitwise logic unit: each result bit is a 4:1 mux over a
// truth table resolved at operand acceptance, with registered zero/parity flags.

package mux_gate_unit_pkg;

   typedef enum logic [2:0] {
      OP_OR     = 3'd0,
      OP_AND    = 3'd1,
      OP_NAND   = 3'd2,
      OP_NOR    = 3'd3,
      OP_XOR    = 3'd4,
      OP_XNOR   = 3'd5,
      OP_USER   = 3'd6,
      OP_PASS_A = 3'd7
   } op_e;

   // Truth tables indexed by {a,b}; bit 0 is the a=0,b=0 entry.
   localparam logic [3:0] TT_OR     = 4'b1110;
   localparam logic [3:0] TT_AND    = 4'b1000;
   localparam logic [3:0] TT_NAND   = 4'b0111;
   localparam logic [3:0] TT_NOR    = 4'b0001;
   localparam logic [3:0] TT_XOR    = 4'b0110;
   localparam logic [3:0] TT_XNOR   = 4'b1001;
   localparam logic [3:0] TT_PASS_A = 4'b1100;

endpackage

module mux_gate_unit
   import mux_gate_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_lut,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_parity
);

   logic [3:0]       user_tt;
   logic [3:0]       resolved_tt;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_tt;

   logic [WIDTH-1:0] y_c;
   logic             s2_adv;
   logic             in_fire;

   // Flow control: S2 advances when it is empty or its result leaves this cycle.
   assign s2_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = rst_n && (!s1_valid || s2_adv);
   assign in_fire  = in_valid && in_ready;

   // NOTE: every combinational output gets a default before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      resolved_tt = TT_PASS_A;
      case (op_e'(in_op))
         OP_OR:     resolved_tt = TT_OR;
         OP_AND:    resolved_tt = TT_AND;
         OP_NAND:   resolved_tt = TT_NAND;
         OP_NOR:    resolved_tt = TT_NOR;
         OP_XOR:    resolved_tt = TT_XOR;
         OP_XNOR:   resolved_tt = TT_XNOR;
         OP_USER:   resolved_tt = user_tt;
         OP_PASS_A: resolved_tt = TT_PASS_A;
         default:   resolved_tt = TT_PASS_A;
      endcase
   end

   always_comb begin
      y_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         y_c[i] = s1_tt[{s1_a[i], s1_b[i]}];
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge value of every other register, regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         user_tt <= 4'b0000;
      end else if (cfg_we) begin
         user_tt <= cfg_lut;
      end
   end

   // USER resolves against user_tt before this edge, so a write in the same
   // cycle only affects later transfers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tt    <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_a     <= in_a;
         s1_b     <= in_b;
         s1_tt    <= resolved_tt;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_y      <= '0;
         out_zero   <= 1'b0;
         out_parity <= 1'b0;
      end else if (s2_adv) begin
         out_valid  <= 1'b1;
         out_y      <= y_c;
         out_zero   <= ~|y_c;
         out_parity <= ^y_c;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_gate_unit.sv
// Directed and scoreboarded checks for mux_gate_unit (WIDTH=8): fixed ops, user
// table timing, zero flag, backpressure, random stress and mid-stream reset.

module tb_mux_gate_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_op;
   logic       cfg_we;
   logic [3:0] cfg_lut;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic       out_zero;
   logic       out_parity;

   int n_tests = 0;
   int n_fail  = 0;

   mux_gate_unit #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .cfg_we     (cfg_we),
      .cfg_lut    (cfg_lut),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_zero   (out_zero),
      .out_parity (out_parity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] tt_of(input logic [2:0] op, input logic [3:0] user);
      case (op)
         3'd0:    return 4'b1110;
         3'd1:    return 4'b1000;
         3'd2:    return 4'b0111;
         3'd3:    return 4'b0001;
         3'd4:    return 4'b0110;
         3'd5:    return 4'b1001;
         3'd6:    return user;
         default: return 4'b1100;
      endcase
   endfunction

   function automatic logic [7:0] apply_tt(input logic [3:0] tt, input logic [7:0] a, input logic [7:0] b);
      logic [7:0] y;
      for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
      return y;
   endfunction

   // Called at a falling edge with the pipeline empty or draining and out_ready=1.
   task automatic do_one(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic we, input logic [3:0] lut,
                         input logic [7:0] exp_y);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; cfg_we = we; cfg_lut = lut;
      #1 check({tag, "_rdy"}, in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; cfg_we = 1'b0;
      check({tag, "_lat1"}, out_valid, 0);
      @(negedge clk);
      check({tag, "_ov"}, out_valid, 1);
      check({tag, "_y"}, out_y, exp_y);
      check({tag, "_zero"}, out_zero, exp_y == 8'h00);
      check({tag, "_par"}, out_parity, ^exp_y);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   initial begin
      logic [2:0] fx_op [7];
      logic [7:0] fx_y  [7];
      logic [7:0] ba [4];
      logic [7:0] bb [4];
      logic [7:0] held;
      logic [7:0] q [$];
      logic [3:0] user_m;
      logic       m_s1v, m_ov, exp_rdy, i_fire, o_fire, adv;
      int         k, got, cyc, n_in, n_out;

      fx_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
      fx_y  = '{8'hDE, 8'h48, 8'hB7, 8'h21, 8'h96, 8'h69, 8'hCA};
      ba    = '{8'h12, 8'hA5, 8'hFF, 8'h3C};
      bb    = '{8'h34, 8'h0F, 8'h81, 8'h3C};

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
      cfg_we = 1'b0; cfg_lut = '0; out_ready = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_zero", out_zero, 0);
      check("rst_out_parity", out_parity, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_ready", in_ready, 1);

      // Fixed gate functions on a=CA, b=5C
      for (int i = 0; i < 7; i++) begin
         do_one($sformatf("fixed_op%0d", fx_op[i]), fx_op[i], 8'hCA, 8'h5C, 1'b0, 4'h0, fx_y[i]);
      end

      do_one("zero_and", 3'd1, 8'h0F, 8'hF0, 1'b0, 4'h0, 8'h00);

      // User table: 0100 is a&~b; a write of 1010 (=b) coinciding with an
      // acceptance only affects the following transfer.
      @(negedge clk);
      cfg_we = 1'b1; cfg_lut = 4'b0100;
      @(negedge clk);
      cfg_we = 1'b0;
      do_one("user_first", 3'd6, 8'hF0, 8'h3C, 1'b0, 4'h0, 8'hC0);
      do_one("user_samecyc", 3'd6, 8'hF0, 8'h3C, 1'b1, 4'b1010, 8'hC0);
      do_one("user_next", 3'd6, 8'hF0, 8'h3C, 1'b0, 4'h0, 8'h3C);

      // Backpressure: drain, then offer 4 XOR transfers with out_ready low
      @(negedge clk);
      out_ready = 1'b0;
      k = 0;
      held = '0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1; in_op = 3'd4; in_a = ba[k]; in_b = bb[k];
         #1;
         if (c == 2) held = out_y;
         if (c == 3) check("bp_y_stable", out_y, held);
         if (in_ready) k++;
         @(negedge clk);
      end
      #1;
      check("bp_accepted", k, 2);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_head_y", out_y, ba[0] ^ bb[0]);
      out_ready = 1'b1;
      got = 0;
      cyc = 0;
      while (got < 4 && cyc < 20) begin
         in_valid = (k < 4);
         if (k < 4) begin in_a = ba[k]; in_b = bb[k]; end
         #1;
         if (k < 4) check($sformatf("bp_rate%0d", k), in_ready, 1);
         if (out_valid) begin
            check($sformatf("bp_out%0d", got), out_y, ba[got] ^ bb[got]);
            got++;
         end
         if (in_valid && in_ready) k++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp_all_out", got, 4);
      @(negedge clk);
      @(negedge clk);

      // Random stress against a flow/queue reference model
      cfg_we = 1'b1; cfg_lut = 4'b0000;
      @(negedge clk);
      cfg_we = 1'b0;
      user_m = 4'b0000; m_s1v = 1'b0; m_ov = 1'b0;
      n_in = 0; n_out = 0; cyc = 0;
      while ((n_in < 1000 || q.size() > 0) && cyc < 20000) begin
         in_valid  = (n_in < 1000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_op     = 3'($urandom_range(0, 7));
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_lut   = 4'($urandom_range(0, 15));
         #1;
         exp_rdy = !m_s1v || !m_ov || out_ready;
         check("st_in_ready", in_ready, exp_rdy);
         check("st_out_valid", out_valid, m_ov);
         if (m_ov && q.size() > 0) begin
            check("st_y", out_y, q[0]);
            check("st_zero", out_zero, q[0] == 8'h00);
            check("st_par", out_parity, ^q[0]);
         end
         i_fire = in_valid && exp_rdy;
         o_fire = m_ov && out_ready;
         adv    = m_s1v && (!m_ov || out_ready);
         if (o_fire && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
         end
         if (i_fire) begin
            q.push_back(apply_tt(tt_of(in_op, user_m), in_a, in_b));
            n_in++;
         end
         if (cfg_we) user_m = cfg_lut;
         m_ov  = adv ? 1'b1 : (o_fire ? 1'b0 : m_ov);
         m_s1v = i_fire ? 1'b1 : (adv ? 1'b0 : m_s1v);
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
      check("st_in_count", n_in, 1000);
      check("st_out_count", n_out, 1000);
      @(negedge clk);

      // Reset with two transactions in flight and a nonzero user table
      out_ready = 1'b0;
      cfg_we = 1'b1; cfg_lut = 4'b1111;
      in_valid = 1'b1; in_op = 3'd4; in_a = 8'hFF; in_b = 8'h00;
      @(negedge clk);
      cfg_we = 1'b0;
      in_a = 8'h0F;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("mid_in_flight", out_valid, 1);
      check("mid_in_flight_y", out_y, 8'hFF);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_ov", out_valid, 0);
      check("mid_rst_y", out_y, 0);
      check("mid_rst_par", out_parity, 0);
      check("mid_rst_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check("mid_rel_ready", in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("mid_no_stale%0d", c), out_valid, 0);
      end
      do_one("mid_user_cleared", 3'd6, 8'hF0, 8'h3C, 1'b0, 4'h0, 8'h00);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
